// File: rtl/jacobian_build.sv
// rtl/jacobian_build.sv - builds the 6x6 geometric Jacobian one column per cycle on a shared multiplier
// Define JACOBIAN_SAT_EN to saturate the d_k and Jv subtractions instead of wrapping modulo 2^W.
module jacobian_build #(
    parameter int W        = 36,
    parameter int MULT_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          start,
    input  logic [5:0][3:0][3:0][W-1:0]   full_matrix,
    input  logic [5:0][W-1:0]             array_mult_result,
    output logic [5:0][W-1:0]             array_mult_dataa,
    output logic [5:0][W-1:0]             array_mult_datab,
    output logic [5:0][5:0][W-1:0]        jacobian,
    output logic                          busy,
    output logic                          done
);
    localparam int FRAC = W / 2;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1} << FRAC;
`ifdef JACOBIAN_SAT_EN
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;
    typedef logic [2:0][W-1:0] vec3_t;

    function automatic logic [W-1:0] sub_w(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef JACOBIAN_SAT_EN
        logic [W:0] diff;
        diff = {a[W-1], a} - {b[W-1], b};
        if (diff[W] != diff[W-1]) begin
            return diff[W] ? SMIN : SMAX;
        end
        return diff[W-1:0];
`else
        return a - b;
`endif
    endfunction

    // Column 0 is the base frame: z = unit z axis, origin at zero.
    function automatic vec3_t z_of(input logic [2:0] k);
        vec3_t v;
        for (int r = 0; r < 3; r++) begin
            if (k == 3'd0) begin
                v[r] = (r == 2) ? ONE : '0;
            end else begin
                v[r] = full_matrix[k - 3'd1][r][2];
            end
        end
        return v;
    endfunction

    function automatic vec3_t p_of(input logic [2:0] k);
        vec3_t v;
        for (int r = 0; r < 3; r++) begin
            if (k == 3'd0) begin
                v[r] = '0;
            end else begin
                v[r] = full_matrix[k - 3'd1][r][3];
            end
        end
        return v;
    endfunction

    state_t                 state_q, state_d;
    logic [2:0]             col_q, col_d;
    logic [1:0]             drain_q, drain_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [5:0][W-1:0]      dataa_q, dataa_d;
    logic [5:0][W-1:0]      datab_q, datab_d;
    logic [5:0][5:0][W-1:0] jac_q, jac_d;

    logic                   issue_v;
    logic [2:0]             issue_col;
    logic                   wb_v;
    logic [2:0]             wb_col;

    logic [2:0]             col_n;
    vec3_t                  z_n, p_n, d_n, p_e, z_wb, jv;
    logic [5:0][W-1:0]      ops_a, ops_b;

    assign issue_v   = (state_q == S_ISSUE);
    assign issue_col = col_q;

    // Writeback tracks the issued column through the multiplier latency.
    generate
        if (MULT_LAT == 0) begin : g_nolat
            assign wb_v   = issue_v;
            assign wb_col = issue_col;
        end else begin : g_lat
            logic [MULT_LAT-1:0]      v_q, v_d;
            logic [MULT_LAT-1:0][2:0] c_q, c_d;

            always_comb begin
                v_d = v_q;
                c_d = c_q;
                if (en) begin
                    v_d[0] = issue_v;
                    c_d[0] = issue_col;
                    for (int i = 1; i < MULT_LAT; i++) begin
                        v_d[i] = v_q[i-1];
                        c_d[i] = c_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= '0;
                    c_q <= '0;
                end else begin
                    v_q <= v_d;
                    c_q <= c_d;
                end
            end

            assign wb_v   = v_q[MULT_LAT-1];
            assign wb_col = c_q[MULT_LAT-1];
        end
    endgenerate

    always_comb begin
        col_n = (state_q == S_ISSUE) ? col_q + 3'd1 : 3'd0;
        z_n   = z_of(col_n);
        p_n   = p_of(col_n);
        for (int r = 0; r < 3; r++) begin
            p_e[r] = full_matrix[5][r][3];
            d_n[r] = sub_w(p_e[r], p_n[r]);
        end
        ops_a = {z_n[1], z_n[0], z_n[0], z_n[2], z_n[2], z_n[1]};
        ops_b = {d_n[0], d_n[1], d_n[2], d_n[0], d_n[1], d_n[2]};
        z_wb  = z_of(wb_col);
        jv[0] = sub_w(array_mult_result[0], array_mult_result[1]);
        jv[1] = sub_w(array_mult_result[2], array_mult_result[3]);
        jv[2] = sub_w(array_mult_result[4], array_mult_result[5]);
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        drain_d = drain_q;
        busy_d  = busy_q;
        done_d  = done_q;
        dataa_d = dataa_q;
        datab_d = datab_q;
        jac_d   = jac_q;
        if (en) begin
            done_d  = 1'b0;
            dataa_d = '0;
            datab_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_ISSUE;
                        col_d   = 3'd0;
                        busy_d  = 1'b1;
                        dataa_d = ops_a;
                        datab_d = ops_b;
                    end
                end
                S_ISSUE: begin
                    if (col_q == 3'd5) begin
                        col_d = 3'd0;
                        if (MULT_LAT == 0) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                            drain_d = 2'd0;
                        end
                    end else begin
                        col_d   = col_q + 3'd1;
                        dataa_d = ops_a;
                        datab_d = ops_b;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == 2'(MULT_LAT - 1)) begin
                        state_d = S_IDLE;
                        drain_d = 2'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        drain_d = drain_q + 2'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (wb_v) begin
                jac_d[wb_col] = {z_wb, jv};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dataa_q <= '0;
            datab_q <= '0;
            jac_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dataa_q <= dataa_d;
            datab_q <= datab_d;
            jac_q   <= jac_d;
        end
    end

    assign array_mult_dataa = dataa_q;
    assign array_mult_datab = datab_q;
    assign jacobian         = jac_q;
    assign busy             = busy_q;
    assign done             = done_q;
endmodule
